// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory responder.
package mem_pkg;

    localparam int unsigned DEFAULT_DEPTH   = 32;
    localparam int unsigned DEFAULT_LATENCY = 2;

    // funct3-style access size codes
    typedef enum logic [2:0] {
        SZ_B   = 3'b000,
        SZ_H   = 3'b001,
        SZ_W   = 3'b010,
        SZ_D   = 3'b011,
        SZ_BU  = 3'b100,
        SZ_HU  = 3'b101,
        SZ_WU  = 3'b110,
        SZ_ILL = 3'b111
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // log2 of the access size comes from the low two bits of the size code
    function automatic logic misaligned(input logic [2:0] lane, input logic [1:0] log2sz);
        logic m;
        case (log2sz)
            2'd0:    m = 1'b0;
            2'd1:    m = lane[0];
            2'd2:    m = |lane[1:0];
            default: m = |lane;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte lane(s) of a 64-bit word and sign/zero extends.
module load_extend
    import mem_pkg::*;
(
    input  logic [63:0] word_i,
    input  logic [2:0]  lane_i,
    input  logic [2:0]  size_i,
    output logic [63:0] rdata_o
);

    logic [63:0] shifted;

    // align the addressed lane to bit 0, then extend according to size
    always_comb begin
        shifted = word_i >> {lane_i, 3'b000};
        case (size_i)
            SZ_B:    rdata_o = {{56{shifted[7]}},  shifted[7:0]};
            SZ_H:    rdata_o = {{48{shifted[15]}}, shifted[15:0]};
            SZ_W:    rdata_o = {{32{shifted[31]}}, shifted[31:0]};
            SZ_D:    rdata_o = shifted;
            SZ_BU:   rdata_o = {56'd0, shifted[7:0]};
            SZ_HU:   rdata_o = {48'd0, shifted[15:0]};
            SZ_WU:   rdata_o = {32'd0, shifted[31:0]};
            default: rdata_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding load/store responder with a fixed wait latency.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH   = DEFAULT_DEPTH,
    parameter int unsigned LATENCY = DEFAULT_LATENCY
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNTW  = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam logic [63:0] LIMIT = 64'(DEPTH) * 64'd8;

    state_e            state_q;
    logic [CNTW-1:0]   cnt_q;
    logic              we_q;
    logic [63:0]       addr_q;
    logic [2:0]        size_q;
    logic [63:0]       wdata_q;
    logic              req_ready_q;
    logic              resp_valid_q;
    logic [63:0]       resp_rdata_q;
    logic              resp_err_q;

    logic [63:0]       mem_q [DEPTH];

    logic [IDXW-1:0]   word_idx;
    logic [63:0]       old_word;
    logic [63:0]       load_data;
    logic              err_d;
    logic [63:0]       rdata_d;
    logic [63:0]       word_d;
    logic [7:0]        size_mask;
    logic [7:0]        lane_mask;
    logic [63:0]       bit_mask;
    logic [63:0]       wdata_shift;
    logic              commit;

    assign word_idx   = addr_q[IDXW+2:3];
    assign old_word   = mem_q[word_idx];
    assign commit     = (state_q == ST_BUSY) && (cnt_q == '0);

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    load_extend u_load_extend (
        .word_i  (old_word),
        .lane_i  (addr_q[2:0]),
        .size_i  (size_q),
        .rdata_o (load_data)
    );

    // classify the captured access and form the load result
    always_comb begin
        err_d = 1'b0;
        if (size_q == SZ_ILL)                       err_d = 1'b1;
        if (misaligned(addr_q[2:0], size_q[1:0]))   err_d = 1'b1;
        if (addr_q >= LIMIT)                        err_d = 1'b1;
        if (we_q && size_q[2])                      err_d = 1'b1;
        rdata_d = (err_d || we_q) ? '0 : load_data;
    end

    // merge store data into the addressed bytes of the current word
    always_comb begin
        case (size_q[1:0])
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
        lane_mask = size_mask << addr_q[2:0];
        for (int unsigned i = 0; i < 8; i++) begin
            bit_mask[i*8 +: 8] = {8{lane_mask[i]}};
        end
        wdata_shift = wdata_q << {addr_q[2:0], 3'b000};
        word_d      = (old_word & ~bit_mask) | (wdata_shift & bit_mask);
    end

    // storage is not reset; a write happens only on a committing, error-free store
    always_ff @(posedge clock) begin
        if (commit && we_q && !err_d) begin
            mem_q[word_idx] <= word_d;
        end
    end

    // IDLE -> BUSY (count down LATENCY) -> RESP (hold until taken) -> IDLE
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            size_q       <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        we_q        <= req_we;
                        addr_q      <= req_addr;
                        size_q      <= req_size;
                        wdata_q     <= req_wdata;
                        cnt_q       <= CNTW'(LATENCY);
                        req_ready_q <= 1'b0;
                        state_q     <= ST_BUSY;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == '0) begin
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= rdata_d;
                        resp_err_q   <= err_d;
                        state_q      <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - CNTW'(1);
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_rdata_q <= '0;
                        resp_err_q   <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: vector table plus scoreboard queue.
module tb_mem_responder;
    import mem_pkg::*;

    localparam int unsigned LAT = 2;

    logic        clock      = 1'b0;
    logic        reset      = 1'b0;
    logic        req_valid  = 1'b0;
    logic        req_ready;
    logic        req_we     = 1'b0;
    logic [63:0] req_addr   = '0;
    logic [2:0]  req_size   = '0;
    logic [63:0] req_wdata  = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_rdata;
    logic        resp_err;

    always #5 clock = ~clock;

    mem_responder #(.DEPTH(32), .LATENCY(LAT)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        err;
        string       name;
    } vec_t;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        string       name;
    } exp_t;

    exp_t sbq[$];
    vec_t vt[28];
    int   nvec = 0;
    int   nmis = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [63:0] addr, input logic [2:0] size,
                                input logic [63:0] wdata, input logic [63:0] rdata, input logic err,
                                input string name);
        vec_t v;
        v.we = we; v.addr = addr; v.size = size; v.wdata = wdata;
        v.rdata = rdata; v.err = err; v.name = name;
        return v;
    endfunction

    // drive a request, wait (bounded) for acceptance, record the expectation
    task automatic issue(input vec_t v, output bit ok);
        int n;
        exp_t e;
        n = 0;
        @(negedge clock);
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_size  = v.size;
        req_wdata = v.wdata;
        while (!req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) begin
            check({v.name, " accept_timeout"}, 64'(req_ready), 64'd1);
            req_valid = 1'b0;
            ok = 1'b0;
            return;
        end
        e.rdata = v.rdata; e.err = v.err; e.name = v.name;
        sbq.push_back(e);
        @(posedge clock);
        #1 req_valid = 1'b0;
        ok = 1'b1;
    endtask

    // count edges from the accepting edge until resp_valid is seen
    task automatic wait_resp(output int edges);
        edges = 0;
        do begin
            @(posedge clock);
            #1;
            edges++;
        end while (!resp_valid && edges < 30);
    endtask

    // wait for a response, compare with the scoreboard head, complete the handshake
    task automatic collect();
        int   edges;
        exp_t e;
        wait_resp(edges);
        if (sbq.size() == 0) return;
        e = sbq.pop_front();
        check({e.name, " latency"}, 64'(edges), 64'(LAT + 1));
        if (!resp_valid) return;
        check({e.name, " rdata"}, resp_rdata, e.rdata);
        check({e.name, " err"}, 64'(resp_err), 64'(e.err));
        @(negedge clock);
        resp_ready = 1'b1;
        @(posedge clock);
        #1 resp_ready = 1'b0;
        check({e.name, " valid_drop"}, 64'(resp_valid), 64'd0);
    endtask

    task automatic run(input vec_t v);
        bit ok;
        issue(v, ok);
        if (ok) collect();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   edges;
        bit   ok;
        exp_t e;

        vt[0]  = mk(1, 64'h10,  3'b011, 64'h1122334455667788, 64'h0,                0, "sd_10");
        vt[1]  = mk(0, 64'h10,  3'b011, 64'h0, 64'h1122334455667788,                0, "ld_10");
        vt[2]  = mk(1, 64'h10,  3'b000, 64'h80, 64'h0,                               0, "sb_10");
        vt[3]  = mk(0, 64'h10,  3'b000, 64'h0, 64'hFFFFFFFFFFFFFF80,                0, "lb_10");
        vt[4]  = mk(0, 64'h10,  3'b100, 64'h0, 64'h80,                               0, "lbu_10");
        vt[5]  = mk(0, 64'h16,  3'b101, 64'h0, 64'h1122,                             0, "lhu_16");
        vt[6]  = mk(0, 64'h10,  3'b011, 64'h0, 64'h1122334455667780,                0, "ld_10_sb");
        vt[7]  = mk(0, 64'h12,  3'b010, 64'h0, 64'h0,                                1, "lw_12_mis");
        vt[8]  = mk(1, 64'h12,  3'b010, 64'hAABBCCDD, 64'h0,                         1, "sw_12_mis");
        vt[9]  = mk(0, 64'h10,  3'b011, 64'h0, 64'h1122334455667780,                0, "ld_10_nochg");
        vt[10] = mk(0, 64'h100, 3'b011, 64'h0, 64'h0,                                1, "ld_100_oob");
        vt[11] = mk(0, 64'h10,  3'b111, 64'h0, 64'h0,                                1, "size_111");
        vt[12] = mk(1, 64'h14,  3'b001, 64'hFFFF8001, 64'h0,                         0, "sh_14");
        vt[13] = mk(0, 64'h14,  3'b001, 64'h0, 64'hFFFFFFFFFFFF8001,                0, "lh_14");
        vt[14] = mk(0, 64'h14,  3'b010, 64'h0, 64'h0000000011228001,                0, "lw_14");
        vt[15] = mk(0, 64'h10,  3'b110, 64'h0, 64'h55667780,                         0, "lwu_10");
        vt[16] = mk(1, 64'h8,   3'b010, 64'h80000001, 64'h0,                         0, "sw_08");
        vt[17] = mk(0, 64'h8,   3'b010, 64'h0, 64'hFFFFFFFF80000001,                0, "lw_08");
        vt[18] = mk(0, 64'h8,   3'b110, 64'h0, 64'h80000001,                         0, "lwu_08");
        vt[19] = mk(1, 64'h10,  3'b100, 64'hFF, 64'h0,                               1, "store_1xx");
        vt[20] = mk(0, 64'h10,  3'b011, 64'h0, 64'h1122800155667780,                0, "ld_10_sh");
        vt[21] = mk(1, 64'hF8,  3'b011, 64'h0123456789ABCDEF, 64'h0,                0, "sd_f8_last");
        vt[22] = mk(0, 64'hF8,  3'b011, 64'h0, 64'h0123456789ABCDEF,                0, "ld_f8_last");
        vt[23] = mk(0, 64'hF9,  3'b011, 64'h0, 64'h0,                                1, "ld_f9_mis");
        vt[24] = mk(0, 64'h11,  3'b001, 64'h0, 64'h0,                                1, "lh_11_mis");
        vt[25] = mk(0, 64'hFF,  3'b100, 64'h0, 64'h01,                               0, "lbu_ff");
        vt[26] = mk(1, 64'h100, 3'b011, 64'h5555, 64'h0,                             1, "sd_100_oob");
        vt[27] = mk(1, 64'h18,  3'b011, 64'hCAFEBABE12345678, 64'h0,                0, "sd_18");

        // reset state
        repeat (3) @(negedge clock);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'd0);
        check("rst_resp_err", 64'(resp_err), 64'd0);
        reset = 1'b1;
        @(posedge clock);
        #1 check("rst_ready_first_edge", 64'(req_ready), 64'd1);

        foreach (vt[i]) run(vt[i]);

        // backpressure: response must hold while resp_ready is low
        issue(mk(0, 64'h10, 3'b011, 64'h0, 64'h1122800155667780, 0, "bp_ld"), ok);
        if (ok) begin
            wait_resp(edges);
            e = sbq.pop_front();
            check("bp latency", 64'(edges), 64'(LAT + 1));
            @(negedge clock);
            req_valid = 1'b1;
            req_we    = 1'b0;
            req_addr  = 64'h8;
            req_size  = 3'b011;
            for (int k = 0; k < 5; k++) begin
                @(negedge clock);
                check("bp_valid", 64'(resp_valid), 64'd1);
                check("bp_rdata", resp_rdata, e.rdata);
                check("bp_err", 64'(resp_err), 64'(e.err));
                check("bp_req_ready", 64'(req_ready), 64'd0);
            end
            req_valid  = 1'b0;
            resp_ready = 1'b1;
            @(posedge clock);
            #1 resp_ready = 1'b0;
            check("bp_valid_drop", 64'(resp_valid), 64'd0);
            check("bp_ready_back", 64'(req_ready), 64'd1);
            for (int k = 0; k < 5; k++) begin
                @(negedge clock);
                check("bp_no_second", 64'(resp_valid), 64'd0);
            end
        end

        // reset during BUSY drops the pending store
        issue(mk(1, 64'h18, 3'b011, 64'hDEAD, 64'h0, 0, "sd_abort"), ok);
        @(posedge clock);
        #1 check("abort_busy_no_valid", 64'(resp_valid), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("abort_rst_valid", 64'(resp_valid), 64'd0);
        check("abort_rst_rdata", resp_rdata, 64'd0);
        check("abort_rst_err", 64'(resp_err), 64'd0);
        repeat (2) @(negedge clock);
        check("abort_rst_valid_hold", 64'(resp_valid), 64'd0);
        reset = 1'b1;
        sbq.delete();
        @(posedge clock);
        #1 check("abort_ready_after_rst", 64'(req_ready), 64'd1);
        run(mk(0, 64'h18, 3'b011, 64'h0, 64'hCAFEBABE12345678, 0, "ld_18_after_rst"));
        run(mk(0, 64'h10, 3'b011, 64'h0, 64'h1122800155667780, 0, "ld_10_survives"));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 32, number of 64-bit storage words (256 bytes).
REQ-002 The block SHALL have parameter LATENCY, default 2, wait cycles spent in BUSY before the access commits.
REQ-003 The block SHALL have port clock  in  1  single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-005 The block SHALL have port req_valid  in  1  request offered by the datapath/control side.
REQ-006 The block SHALL have port req_ready  out  1  block can accept a request this cycle.
REQ-007 The block SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-008 The block SHALL have port req_addr  in  64  byte address.
REQ-009 The block SHALL have port req_size  in  3  funct3 code: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu, 111 illegal.
REQ-010 The block SHALL have port req_wdata  in  64  store data, low-justified.
REQ-011 The block SHALL have port resp_valid  out  1  response available.
REQ-012 The block SHALL have port resp_ready  in  1  requester takes the response.
REQ-013 The block SHALL have port resp_rdata  out  64  load result, extended to 64 bits; 0 for stores and errors.
REQ-014 The block SHALL have port resp_err  out  1  access rejected.

Function
REQ-015 The FSM SHALL have states IDLE, BUSY and RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 In IDLE, req_valid & req_ready SHALL capture we/addr/size/wdata, load the wait counter with LATENCY and go to BUSY.
REQ-017 In BUSY, the counter SHALL decrement each cycle; at counter==0 the access SHALL commit on that edge, resp_rdata/resp_err SHALL be registered and the FSM SHALL go to RESP.
REQ-018 resp_valid SHALL first be high LATENCY+1 edges after the accepting edge (3 edges for LATENCY=2).
REQ-019 In RESP, resp_valid SHALL be 1 and resp_rdata/resp_err SHALL hold stable until resp_valid & resp_ready, then the FSM SHALL go to IDLE.
REQ-020 A new request SHALL be accepted no earlier than the cycle after the response handshake; req_valid outside IDLE SHALL be ignored.
REQ-021 Addressing SHALL be little-endian: word index = addr[63:3], byte lane = addr[2:0].
REQ-022 Stores SHALL update only the addressed 1/2/4/8 bytes and leave the other bytes of the word unchanged.
REQ-023 Loads b/h/w SHALL sign-extend, bu/hu/wu SHALL zero-extend, and d SHALL return the full word.
REQ-024 An access SHALL be an error if addr is not a multiple of the access size, addr >= DEPTH*8, or size==111; a size 1xx store SHALL also be an error.
REQ-025 An error access SHALL give resp_err=1 and resp_rdata=0, and SHALL NOT modify storage.

Reset
REQ-026 While reset==0, the block SHALL hold state=IDLE, counter=0, resp_valid=0, resp_rdata=0 and resp_err=0; req_ready SHALL be 1 from the first edge after reset deasserts.
REQ-027 Reset mid-operation SHALL abort the pending access, and an uncommitted store SHALL be dropped.
REQ-028 Storage SHALL NOT be reset, and its contents SHALL survive reset.

Structure
REQ-029 The size-code enum, state enum and default DEPTH/LATENCY SHALL live in shared package mem_pkg.
REQ-030 Load lane selection and extension SHALL be one combinational sub-module, load_extend.

Verification
REQ-031 sd 0x10 data 0x1122334455667788, then ld 0x10 -> rdata 0x1122334455667788, err 0, resp_valid on the 3rd edge after accept.
REQ-032 sb 0x10 data 0x80, then lb 0x10 -> 0xFFFFFFFFFFFFFF80; lbu 0x10 -> 0x80; lhu 0x16 -> 0x1122.
REQ-033 lw 0x12 -> err 1, rdata 0; sw 0x12 -> err 1, and ld 0x10 afterwards is unchanged.
REQ-034 ld 0x100 and size 111 -> err 1.
REQ-035 resp_ready held 0 for 5 cycles with req_valid=1 -> resp_valid, rdata and err stable; req_ready 0; no second accept.
REQ-036 reset pulsed during BUSY of sd 0x18 with 0xDEAD -> resp_valid 0; ld 0x18 after reset returns the pre-store value.
